// File: rtl/uart_transmitter.sv
// ============================================================================
// uart_transmitter
// ----------------------------------------------------------------------------
// Purpose:
//   8-bit UART transmitter with a one-entry holding buffer.
//   Frame order: start(0), data[0..7] (LSB first), parity, stop(1).
//   Parity is XOR of the data byte, inverted when PARITY_ODD=1.
//   When a byte is waiting in the buffer at the end of a stop bit, the next
//   start bit follows immediately, so there are no idle cycles between frames.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (1..255)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   data[7:0]   in   byte to send, sampled on an accepting edge
//   send_valid  in   transmit request
//   send_ready  out  holding buffer empty (registered)
//   tx          out  serial line, registered, idle high
//   busy        out  high in every state except IDLE (registered)
//   done        out  one-cycle pulse at the end of each frame (registered)
//   debug[7:0]  out  {5'b0, state code}
// ============================================================================
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       send_valid,
    output logic       send_ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] debug
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     r_state;
    logic [7:0] r_buf;
    logic       r_send_ready;   // doubles as the "buffer empty" flag
    logic [7:0] r_shift;
    logic       r_parity;
    logic [2:0] r_idx;
    logic [7:0] r_baud;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_bit_end;
    logic       w_reload;

    assign w_accept  = send_valid & r_send_ready;
    // With CLKS_PER_BIT=1 BAUD_MAX is 0, so every cycle ends a bit and the
    // counter never leaves 0.
    assign w_bit_end = (r_baud == BAUD_MAX);
    // The buffer is drained either from IDLE or straight out of a finished
    // stop bit. Reload needs a full buffer and acceptance an empty one, so
    // the two can never happen on the same edge.
    assign w_reload  = ~r_send_ready &
                       ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_buf        <= 8'd0;
            r_send_ready <= 1'b1;
            r_shift      <= 8'd0;
            r_parity     <= 1'b0;
            r_idx        <= 3'd0;
            r_baud       <= 8'd0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_buf        <= data;
                r_send_ready <= 1'b0;
            end

            if (w_reload) begin
                r_shift      <= r_buf;
                r_parity     <= (^r_buf) ^ PARITY_ODD;
                r_send_ready <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_baud <= 8'd0;
                    if (w_reload) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= 8'd0;
                        r_idx   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud  <= r_baud + 8'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= 8'd0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_shift[r_idx + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= 8'd0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud  <= r_baud + 8'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= 8'd0;
                        r_done <= 1'b1;
                        if (w_reload) begin
                            // Back-to-back: next start bit with no idle gap.
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= 8'd0;
                end
            endcase
        end
    end

    assign send_ready = r_send_ready;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign debug      = {5'b0, r_state};

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // DUT A: CLKS_PER_BIT=1, even parity
    logic [7:0] a_data = 8'd0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_tx, a_busy, a_done;
    logic [7:0] a_debug;

    // DUT B: CLKS_PER_BIT=4, odd parity
    logic [7:0] b_data = 8'd0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_tx, b_busy, b_done;
    logic [7:0] b_debug;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .data(a_data), .send_valid(a_valid),
        .send_ready(a_ready), .tx(a_tx), .busy(a_busy), .done(a_done),
        .debug(a_debug)
    );

    uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .data(b_data), .send_valid(b_valid),
        .send_ready(b_ready), .tx(b_tx), .busy(b_busy), .done(b_done),
        .debug(b_debug)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit j (0..10) of a frame in transmit order.
    function automatic logic frame_bit(input logic [7:0] d, input logic odd, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (j == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        checks++; if (a_tx !== 1'b1)     begin errors++; $display("FAIL reset_a_tx got %b want 1", a_tx); end
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL reset_a_ready got %b want 1", a_ready); end
        checks++; if (a_busy !== 1'b0)   begin errors++; $display("FAIL reset_a_busy got %b want 0", a_busy); end
        checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL reset_a_done got %b want 0", a_done); end
        checks++; if (a_debug !== 8'h00) begin errors++; $display("FAIL reset_a_debug got %h want 00", a_debug); end
        checks++; if (b_tx !== 1'b1)     begin errors++; $display("FAIL reset_b_tx got %b want 1", b_tx); end
        checks++; if (b_ready !== 1'b1)  begin errors++; $display("FAIL reset_b_ready got %b want 1", b_ready); end
        tick();
        #2 rst_n = 1'b1;
        tick();
        checks++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle tx=%b busy=%b want tx=1 busy=0", a_tx, a_busy);
        end
    endtask

    // A5 with CLKS_PER_BIT=1: hand-derived line sequence after edges N+1..N+11.
    task automatic test_frame_a5();
        logic [0:10] exp;
        exp = 11'b01010010101;
        a_data = 8'hA5; a_valid = 1'b1;
        tick();                        // edge N: accepted
        a_valid = 1'b0; a_data = 8'h00; // later data changes must not matter
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL a5_ready_after_accept got %b want 0", a_ready); end
        checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL a5_busy_at_N got %b want 0", a_busy); end
        for (int k = 1; k <= 11; k++) begin
            tick();
            checks++; if (a_tx !== exp[k-1]) begin errors++; $display("FAIL a5_tx edge N+%0d got %b want %b", k, a_tx, exp[k-1]); end
            checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL a5_done_early edge N+%0d got %b want 0", k, a_done); end
            checks++; if (a_busy !== 1'b1)   begin errors++; $display("FAIL a5_busy edge N+%0d got %b want 1", k, a_busy); end
        end
        tick();                        // edge N+12
        checks++; if (a_done !== 1'b1)   begin errors++; $display("FAIL a5_done got %b want 1", a_done); end
        checks++; if (a_tx !== 1'b1)     begin errors++; $display("FAIL a5_idle_tx got %b want 1", a_tx); end
        checks++; if (a_busy !== 1'b0)   begin errors++; $display("FAIL a5_idle_busy got %b want 0", a_busy); end
        checks++; if (a_debug !== 8'h00) begin errors++; $display("FAIL a5_idle_debug got %h want 00", a_debug); end
        tick();
        checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL a5_done_width got %b want 0", a_done); end
    endtask

    // 01 then FF as soon as ready: frames abut, busy stays high.
    task automatic test_back_to_back();
        logic exp_tx [0:22];
        logic rec_tx [0:22];
        logic acc;
        int   acc_k = -1;
        for (int j = 0; j < 11; j++) begin
            exp_tx[j]      = frame_bit(8'h01, 1'b0, j);
            exp_tx[j + 11] = frame_bit(8'hFF, 1'b0, j);
        end
        exp_tx[22] = 1'b1;
        a_data = 8'h01; a_valid = 1'b1;
        tick();                        // edge N
        a_data = 8'hFF;
        for (int k = 1; k <= 23; k++) begin
            acc = a_valid & a_ready;
            tick();
            if (acc) begin a_valid = 1'b0; acc_k = k; end
            rec_tx[k-1] = a_tx;
            checks++; if (a_tx !== exp_tx[k-1]) begin errors++; $display("FAIL b2b_tx edge N+%0d got %b want %b", k, a_tx, exp_tx[k-1]); end
            checks++; if (a_done !== ((k == 12) || (k == 23))) begin errors++; $display("FAIL b2b_done edge N+%0d got %b", k, a_done); end
            checks++; if (a_busy !== (k <= 22)) begin errors++; $display("FAIL b2b_busy edge N+%0d got %b", k, a_busy); end
        end
        checks++; if (acc_k != 2)        begin errors++; $display("FAIL b2b_accept_edge got N+%0d want N+2", acc_k); end
        checks++; if (rec_tx[9] !== 1'b1)  begin errors++; $display("FAIL b2b_parity1 got %b want 1", rec_tx[9]); end
        checks++; if (rec_tx[20] !== 1'b0) begin errors++; $display("FAIL b2b_parity2 got %b want 0", rec_tx[20]); end
        checks++; if (rec_tx[11] !== 1'b0) begin errors++; $display("FAIL b2b_no_gap got %b want 0", rec_tx[11]); end
        tick();
    endtask

    // Keep 3C asserted while the buffer is full; it must be taken exactly once.
    task automatic test_hold_valid();
        logic exp_tx [0:44];
        logic acc;
        int   n_acc = 0, acc3c_k = -1, n_done = 0;
        for (int j = 0; j < 11; j++) begin
            exp_tx[j]      = frame_bit(8'h11, 1'b0, j);
            exp_tx[j + 11] = frame_bit(8'h22, 1'b0, j);
            exp_tx[j + 22] = frame_bit(8'h3C, 1'b0, j);
        end
        for (int j = 33; j < 45; j++) exp_tx[j] = 1'b1;
        a_data = 8'h11; a_valid = 1'b1;
        tick();                        // edge N
        a_data = 8'h22;
        for (int k = 1; k <= 45; k++) begin
            acc = a_valid & a_ready;
            tick();
            if (acc) begin
                n_acc++;
                if (a_data == 8'h22) a_data = 8'h3C;
                else begin a_valid = 1'b0; acc3c_k = k; end
            end
            if (a_done === 1'b1) n_done++;
            if (k >= 3 && k <= 11) begin
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL hold_ready edge N+%0d got %b want 0", k, a_ready); end
            end
            checks++; if (a_tx !== exp_tx[k-1]) begin errors++; $display("FAIL hold_tx edge N+%0d got %b want %b", k, a_tx, exp_tx[k-1]); end
        end
        checks++; if (acc3c_k != 13) begin errors++; $display("FAIL hold_3c_accept_edge got N+%0d want N+13", acc3c_k); end
        checks++; if (n_acc != 2)    begin errors++; $display("FAIL hold_accept_count got %0d want 2", n_acc); end
        checks++; if (n_done != 3)   begin errors++; $display("FAIL hold_done_count got %0d want 3", n_done); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL hold_final_busy got %b want 0", a_busy); end
    endtask

    // CLKS_PER_BIT=4, odd parity, 00: 44-cycle frame, parity bit 1.
    task automatic test_cpb4_odd();
        logic exp;
        b_data = 8'h00; b_valid = 1'b1;
        tick();                        // edge N
        b_valid = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (k <= 44) exp = ((k - 1) / 4 >= 9) ? 1'b1 : 1'b0;
            else         exp = 1'b1;
            checks++; if (b_tx !== exp) begin errors++; $display("FAIL cpb4_tx edge N+%0d got %b want %b", k, b_tx, exp); end
            checks++; if (b_done !== (k == 45)) begin errors++; $display("FAIL cpb4_done edge N+%0d got %b", k, b_done); end
            checks++; if (b_busy !== (k <= 44)) begin errors++; $display("FAIL cpb4_busy edge N+%0d got %b", k, b_busy); end
        end
    endtask

    // Reset during data bit 3 with a second byte buffered.
    task automatic test_reset_midframe();
        a_data = 8'h55; a_valid = 1'b1;
        tick();                        // edge N
        a_data = 8'h66;
        tick();                        // N+1: ready rises
        tick();                        // N+2: 66 accepted
        a_valid = 1'b0;
        tick(); tick(); tick();        // N+5: data bit 3
        checks++; if (a_debug !== 8'h02) begin errors++; $display("FAIL mid_state got %h want 02", a_debug); end
        checks++; if (a_tx !== 1'b0)     begin errors++; $display("FAIL mid_bit3 got %b want 0", a_tx); end
        checks++; if (a_ready !== 1'b0)  begin errors++; $display("FAIL mid_buffered got %b want 0", a_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_tx !== 1'b1)     begin errors++; $display("FAIL mid_rst_tx got %b want 1", a_tx); end
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL mid_rst_ready got %b want 1", a_ready); end
        checks++; if (a_busy !== 1'b0)   begin errors++; $display("FAIL mid_rst_busy got %b want 0", a_busy); end
        checks++; if (a_debug !== 8'h00) begin errors++; $display("FAIL mid_rst_debug got %h want 00", a_debug); end
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
                errors++; $display("FAIL post_abort_idle cycle %0d tx=%b busy=%b want 1/0", k, a_tx, a_busy);
            end
        end
        a_data = 8'h0F; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL first_accept_ready got %b want 0", a_ready); end
        tick();
        checks++; if (a_tx !== 1'b0)    begin errors++; $display("FAIL first_accept_start got %b want 0", a_tx); end
        for (int k = 0; k < 14; k++) tick();
        checks++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL first_frame_end tx=%b busy=%b want 1/0", a_tx, a_busy);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_hold_valid();
        test_cpb4_odd();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data  input  8  byte to transmit; sampled only on an accepting edge.
REQ-006 send_valid  input  1  request to transmit data.
REQ-007 send_ready  output  1  holding buffer empty; a byte can be accepted.
REQ-008 tx  output  1  serial line, registered, idle high.
REQ-009 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse per completed frame.
REQ-011 debug  output  8  {5'b0, state code}.

Function
REQ-012 Frame format, in transmit order: start bit 0; data bit 0 (LSB) through bit 7; parity bit; stop bit 1. Total 11 bit periods.
REQ-013 Parity bit value: XOR of data[7:0], inverted when PARITY_ODD=1.
REQ-014 Each bit period lasts exactly CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and clears on every bit advance.
- When CLKS_PER_BIT=1, the counter stays at 0.
REQ-015 One-entry holding buffer; send_ready = ~buffer_full, driven from a register.
REQ-016 Acceptance occurs on an edge where send_valid=1 and send_ready=1.
- data is copied into the buffer and the buffer is marked full.
- send_valid while send_ready=0 is ignored; the requester holds data and send_valid until accepted.
REQ-017 FSM state codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. Any other code returns to IDLE on the next edge with tx=1.
REQ-018 IDLE transitions:
- Buffer full: on the next edge, move the buffer into the shift register, clear the buffer, compute parity, enter START, set tx=0.
- Buffer empty: stay in IDLE with tx=1.
REQ-019 START, DATA and PARITY each hold tx for one bit period.
- START -> DATA, index 0.
- DATA advances index 0..7; tx = shift[index]; after index 7 -> PARITY.
- PARITY -> STOP with tx=1.
REQ-020 At the end of the STOP bit period, done=1 for exactly one cycle.
- Buffer full: go directly to START (tx=0) and reload from the buffer, leaving zero idle cycles between frames.
- Buffer empty: go to IDLE, tx=1.
REQ-021 Latency: acceptance at edge N while IDLE with an empty buffer -> tx=0 after edge N+1. With CLKS_PER_BIT=1, the stop bit is driven after edge N+11 and done=1 after edge N+12.
REQ-022 A new byte may be accepted during any frame state once the buffer is empty. A byte accepted on the same edge as a reload waits for the following frame.
REQ-023 Data is captured at acceptance; changes on the data input after acceptance do not affect the frame.
REQ-024 busy=0 only in IDLE. busy stays 1 across back-to-back frames.

Reset
REQ-025 While rst_n=0, asynchronously set the following, independent of clk:
- state=IDLE, tx=1, send_ready=1, busy=0, done=0, debug=0.
- Buffer empty; baud counter, index and shift register cleared.
REQ-026 Reset asserted mid-frame aborts the frame immediately: tx=1, and the buffered byte is discarded.
REQ-027 After release, the first acceptance is possible on the first rising edge with send_valid=1.

Verification
REQ-028 CLKS_PER_BIT=1, PARITY_ODD=0, accept data=8'hA5 at edge N -> tx after edges N+1..N+11 = 0,1,0,1,0,0,1,0,1,0,1; done=1 after N+12 only.
REQ-029 CLKS_PER_BIT=1: accept 8'h01, then 8'hFF as soon as send_ready=1 -> second start bit immediately follows the first stop bit (no idle cycle); parity bits 1 then 0; done pulses twice; busy never drops between frames.
REQ-030 CLKS_PER_BIT=4, PARITY_ODD=1, data=8'h00 -> each bit held 4 cycles; frame 44 cycles; parity bit 1; tx=1 thereafter.
REQ-031 Hold send_valid=1 with data=8'h3C while send_ready=0 (buffer full during a frame) -> no capture until the reload edge; 8'h3C is sent exactly once.
REQ-032 Assert rst_n=0 during data bit 3 with a byte buffered -> tx=1, send_ready=1, busy=0 immediately. After release with no new request, tx stays 1 and no frame is sent.
